// File: rtl/jump_flush_pkg.sv
// Shared types and constants for the control-transfer flush controller.
package jump_flush_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SHADOW = 2'd2
    } jf_state_t;

    localparam int JF_FLUSH_CYCLES_DEF = 2;
    localparam int JF_SH_CNT_W         = 3;

endpackage

// File: rtl/jump_flush_controller.sv
// Detects taken branches/jumps in EXE, redirects the PC, holds a stalled redirect
// and kills wrong-path instructions for a counted shadow window.
//
// state  | meaning
// IDLE   | no redirect in flight; a take fires here unless stalled
// PEND   | take seen under stall; target latched in tgt_q, fires when stall drops
// SHADOW | post-fire window killing wrong-path work; sh_cnt unstalled cycles remain
module jump_flush_controller
    import jump_flush_pkg::*;
#(
    parameter int FLUSH_CYCLES = JF_FLUSH_CYCLES_DEF,
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_is_branch,
    input  logic              exe_branch_taken,
    input  logic              exe_is_jump,
    input  logic [ADDR_W-1:0] exe_target,
    input  logic              stall,
    output logic              pc_jump_control,
    output logic              enable_jump,
    output logic              local_rst,
    output logic [ADDR_W-1:0] pc_redirect_target,
    output logic              if_id_flush,
    output logic              id_exe_flush,
    output logic [CNT_W-1:0]  jump_count
);

    localparam bit                     HAS_SHADOW = (FLUSH_CYCLES > 1);
    localparam logic [JF_SH_CNT_W-1:0] SH_LOAD    = JF_SH_CNT_W'(FLUSH_CYCLES - 1);

    jf_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       tgt_q, tgt_d;
    logic [JF_SH_CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic                    fire;
    logic                    take;

    assign take = exe_valid & (exe_is_jump | (exe_is_branch & exe_branch_taken));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            sh_cnt_q   <= '0;
            jump_count <= '0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            sh_cnt_q <= sh_cnt_d;
            if (fire) begin
                jump_count <= jump_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        tgt_d              = tgt_q;
        sh_cnt_d           = sh_cnt_q;
        fire               = 1'b0;
        pc_jump_control    = 1'b0;
        enable_jump        = 1'b0;
        local_rst          = 1'b0;
        if_id_flush        = 1'b0;
        id_exe_flush       = 1'b0;
        pc_redirect_target = exe_target;

        case (state_q)
            IDLE: begin
                if (take) begin
                    enable_jump = 1'b1;
                    if (stall) begin
                        tgt_d   = exe_target;
                        state_d = PEND;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            PEND: begin
                enable_jump        = 1'b1;
                pc_redirect_target = tgt_q;
                if (!stall) begin
                    fire = 1'b1;
                end
            end
            SHADOW: begin
                // EXE contents are wrong-path here and deliberately ignored.
                enable_jump  = 1'b1;
                local_rst    = 1'b1;
                id_exe_flush = 1'b1;
                if (!stall) begin
                    sh_cnt_d = sh_cnt_q - JF_SH_CNT_W'(1);
                    if (sh_cnt_q == JF_SH_CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fire) begin
            pc_jump_control = 1'b1;
            local_rst       = 1'b1;
            if_id_flush     = 1'b1;
            id_exe_flush    = 1'b1;
            if (HAS_SHADOW) begin
                state_d  = SHADOW;
                sh_cnt_d = SH_LOAD;
            end else begin
                state_d = IDLE;
            end
        end

        // Outputs are forced quiet while reset is sampled high.
        if (rst) begin
            fire               = 1'b0;
            pc_jump_control    = 1'b0;
            enable_jump        = 1'b0;
            local_rst          = 1'b0;
            if_id_flush        = 1'b0;
            id_exe_flush       = 1'b0;
            pc_redirect_target = '0;
        end
    end

endmodule

// File: tb/tb_jump_flush_controller.sv
// Directed bench for jump_flush_controller: a FLUSH_CYCLES=2 instance (CNT_W=4)
// and a FLUSH_CYCLES=1 instance driven with the same stimulus.
module tb_jump_flush_controller;

    logic        clk;
    logic        rst;
    logic        exe_valid, exe_is_branch, exe_branch_taken, exe_is_jump, stall;
    logic [31:0] exe_target;

    logic        pjc, en, lr, ifid, idexe;
    logic [31:0] tgt;
    logic [3:0]  cnt;
    logic        pjc1, en1, lr1, ifid1, idexe1;
    logic [31:0] tgt1;
    logic [3:0]  cnt1;

    int n_vec = 0;
    int n_err = 0;

    // Output bundle order: {pc_jump_control, enable_jump, local_rst, if_id_flush, id_exe_flush}
    localparam logic [4:0] O_NONE   = 5'b00000;
    localparam logic [4:0] O_FIRE   = 5'b11111;
    localparam logic [4:0] O_SHADOW = 5'b01101;
    localparam logic [4:0] O_PEND   = 5'b01000;

    jump_flush_controller #(.FLUSH_CYCLES(2), .ADDR_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_is_branch(exe_is_branch),
        .exe_branch_taken(exe_branch_taken), .exe_is_jump(exe_is_jump),
        .exe_target(exe_target), .stall(stall),
        .pc_jump_control(pjc), .enable_jump(en), .local_rst(lr),
        .pc_redirect_target(tgt), .if_id_flush(ifid), .id_exe_flush(idexe),
        .jump_count(cnt)
    );

    jump_flush_controller #(.FLUSH_CYCLES(1), .ADDR_W(32), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_is_branch(exe_is_branch),
        .exe_branch_taken(exe_branch_taken), .exe_is_jump(exe_is_jump),
        .exe_target(exe_target), .stall(stall),
        .pc_jump_control(pjc1), .enable_jump(en1), .local_rst(lr1),
        .pc_redirect_target(tgt1), .if_id_flush(ifid1), .id_exe_flush(idexe1),
        .jump_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic br, input logic tk, input logic jp,
                         input logic [31:0] t, input logic st);
        exe_valid        = v;
        exe_is_branch    = br;
        exe_branch_taken = tk;
        exe_is_jump      = jp;
        exe_target       = t;
        stall            = st;
    endtask

    // Sample combinational outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [4:0] eo, input logic [31:0] et);
        @(negedge clk);
        check({tag, ".out"}, {27'd0, pjc, en, lr, ifid, idexe}, {27'd0, eo});
        check({tag, ".tgt"}, tgt, et);
        @(posedge clk);
        #1;
    endtask

    task automatic jal(input logic [31:0] t, input logic st);
        drive(1'b1, 1'b0, 1'b0, 1'b1, t, st);
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        jal(32'h55, 1'b0);
        cyc("rst_quiet", O_NONE, 32'h0);
        check("rst_cnt", {28'd0, cnt}, 32'd0);
        rst = 1'b0;

        idle_in();
        exe_target = 32'h77;
        cyc("idle_pass", O_NONE, 32'h77);

        // Unstalled JAL: zero-latency fire, one shadow cycle, back to IDLE.
        jal(32'h100, 1'b0);
        cyc("jal_fire", O_FIRE, 32'h100);
        check("jal_cnt", {28'd0, cnt}, 32'd1);
        jal(32'h180, 1'b0);
        cyc("jal_shadow", O_SHADOW, 32'h180);
        check("jal_shadow_cnt", {28'd0, cnt}, 32'd1);
        idle_in();
        cyc("jal_idle", O_NONE, 32'h0);

        // Taken branch held by a 3-cycle stall; target stays latched.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h2000, 1'b1);
        cyc("br_stall1", O_PEND, 32'h2000);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h3000, 1'b1);
        cyc("br_stall2", O_PEND, 32'h2000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h4000, 1'b1);
        cyc("br_stall3", O_PEND, 32'h2000);
        check("br_stall_cnt", {28'd0, cnt}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h5000, 1'b0);
        cyc("br_fire", O_FIRE, 32'h2000);
        check("br_cnt", {28'd0, cnt}, 32'd2);
        // Stalled shadow extends one-for-one.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc("sh_stall1", O_SHADOW, 32'h0);
        cyc("sh_stall2", O_SHADOW, 32'h0);
        stall = 1'b0;
        cyc("sh_end", O_SHADOW, 32'h0);
        cyc("sh_idle", O_NONE, 32'h0);

        // Not-taken branch.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 1'b0);
        cyc("nt_branch", O_NONE, 32'h600);
        check("nt_cnt", {28'd0, cnt}, 32'd2);

        // Jump during shadow is ignored; same jump right after shadow fires.
        jal(32'h400, 1'b0);
        cyc("sj_fire", O_FIRE, 32'h400);
        jal(32'h500, 1'b0);
        cyc("sj_ignored", O_SHADOW, 32'h500);
        check("sj_ign_cnt", {28'd0, cnt}, 32'd3);
        cyc("sj_refire", O_FIRE, 32'h500);
        check("sj_refire_cnt", {28'd0, cnt}, 32'd4);
        idle_in();
        cyc("sj_shadow", O_SHADOW, 32'h0);

        // Reset mid-PEND.
        jal(32'h700, 1'b1);
        cyc("rp_pend", O_PEND, 32'h700);
        rst = 1'b1;
        cyc("rp_rst", O_NONE, 32'h0);
        rst = 1'b0;
        idle_in();
        cyc("rp_after", O_NONE, 32'h0);
        check("rp_cnt", {28'd0, cnt}, 32'd0);

        // Reset mid-SHADOW.
        jal(32'h800, 1'b0);
        cyc("rs_fire", O_FIRE, 32'h800);
        idle_in();
        rst = 1'b1;
        cyc("rs_rst", O_NONE, 32'h0);
        rst = 1'b0;
        cyc("rs_after", O_NONE, 32'h0);
        check("rs_cnt", {28'd0, cnt}, 32'd0);

        // FLUSH_CYCLES=1 has no shadow: back-to-back fires on dut1.
        jal(32'h900, 1'b0);
        @(negedge clk);
        check("f1_fire1", {27'd0, pjc1, en1, lr1, ifid1, idexe1}, {27'd0, O_FIRE});
        @(posedge clk); #1;
        jal(32'h940, 1'b0);
        @(negedge clk);
        check("f1_fire2", {27'd0, pjc1, en1, lr1, ifid1, idexe1}, {27'd0, O_FIRE});
        check("f1_tgt2", tgt1, 32'h940);
        check("f1_main_shadow", {27'd0, pjc, en, lr, ifid, idexe}, {27'd0, O_SHADOW});
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        check("f1_idle", {27'd0, pjc1, en1, lr1, ifid1, idexe1}, {27'd0, O_NONE});
        check("f1_cnt", {28'd0, cnt1}, 32'd2);
        @(posedge clk); #1;

        // Counter wrap: 16 fires from reset on a 4-bit counter.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            jal(32'h1000 + 32'(i), 1'b0);
            @(posedge clk); #1;
            idle_in();
            @(posedge clk); #1;
            if (i == 14) check("wrap_15", {28'd0, cnt}, 32'd15);
        end
        check("wrap_0", {28'd0, cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jump_flush_controller.md
# jump_flush_controller

Control-transfer flush generator for the 5-stage pipeline. It detects taken branches and jumps resolved in EXE and drives the PC redirect. It produces the `pc_jump_control`, `enable_jump` and `local_rst` triplet consumed by the per-stage reset controllers, and holds a pending redirect across pipeline stalls. After each redirect it runs a counted shadow window that kills wrong-path instructions, and it keeps a taken-transfer performance counter.

## Interface
- `FLUSH_CYCLES`, default 2: total flush cycles per redirect, including the fire cycle; legal range 1..7.
- `ADDR_W`, default 32: PC/target width.
- `CNT_W`, default 16: `jump_count` width.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `exe_valid`  in  1  — EXE holds a valid instruction.
- `exe_is_branch`  in  1  — EXE instruction is a conditional branch.
- `exe_branch_taken`  in  1  — branch condition true; only meaningful with `exe_is_branch`.
- `exe_is_jump`  in  1  — EXE instruction is JAL/JALR.
- `exe_target`  in  ADDR_W  — resolved target address.
- `stall`  in  1  — pipeline hold (memory wait); the pipeline does not advance this cycle.
- `pc_jump_control`  out  1  — redirect is applied this cycle.
- `enable_jump`  out  1  — controller is active (fire, pending or shadow).
- `local_rst`  out  1  — flush request to the stage reset controllers.
- `pc_redirect_target`  out  ADDR_W  — PC load value; valid when `pc_jump_control`=1.
- `if_id_flush`  out  1  — kill the IF/ID register at this edge.
- `id_exe_flush`  out  1  — kill the ID/EXE register at this edge.
- `jump_count`  out  CNT_W  — number of fired redirects; wraps.

## Operation
- take = `exe_valid` & (`exe_is_jump` | (`exe_is_branch` & `exe_branch_taken`)).
- Outputs are Mealy: a function of state and current inputs. While `rst`=1, all outputs are 0.
- States: IDLE, PEND, SHADOW.
- **IDLE, no take**
  - All outputs 0; `pc_redirect_target` = `exe_target`.
- **IDLE, take & !stall (fire)**
  - Outputs: `pc_jump_control`=`enable_jump`=`local_rst`=`if_id_flush`=`id_exe_flush`=1; `pc_redirect_target`=`exe_target`.
  - At the edge: `jump_count`+1.
  - Next state: SHADOW with `sh_cnt`=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else IDLE.
- **IDLE, take & stall**
  - Outputs: `enable_jump`=1, everything else 0.
  - At the edge: `tgt_q` ← `exe_target`; next state PEND.
- **PEND**
  - `enable_jump`=1; `pc_redirect_target`=`tgt_q`. EXE inputs are ignored.
  - While `stall`=1: stay in PEND, all other outputs 0.
  - First cycle with `stall`=0: fire exactly as in IDLE, but using `tgt_q`.
- **SHADOW**
  - Outputs: `enable_jump`=`local_rst`=`id_exe_flush`=1; `pc_jump_control`=`if_id_flush`=0.
  - EXE inputs are ignored: they are wrong-path, so there is no fire and no count.
  - `stall`=1: `sh_cnt` holds.
  - `stall`=0: `sh_cnt` decrements. When `sh_cnt`=1 and `stall`=0, next state is IDLE.
- **Counter**
  - `jump_count` is CNT_W bits and wraps from all-ones to 0.
  - It increments only on fire edges, never while stalled.
- **Downstream relation**
  - A stage reset controller computes `rst` | (`enable_jump` & `pc_jump_control` & `local_rst`). That term is 1 only on fire cycles.

## Timing
- Fire happens in the same cycle as detection: zero-cycle redirect latency when not stalled.
- PC loads `pc_redirect_target` at the fire edge.
- A stalled redirect fires in the first cycle `stall` drops. `pc_redirect_target` is stable (`tgt_q`) for the entire PEND interval.
- Shadow length is exactly FLUSH_CYCLES-1 unstalled cycles after the fire cycle. Stall cycles extend it one-for-one.
- A take in the cycle immediately after the shadow ends (back in IDLE) fires normally; there are no dead cycles.
- Reset:
  - `rst` sampled high forces state IDLE, `sh_cnt`=0, `tgt_q`=0 and `jump_count`=0 at the edge.
  - Reset takes priority over fire, pending and shadow, including mid-PEND and mid-SHADOW.
  - The first post-reset cycle behaves as IDLE.
- Register reset values: state=IDLE, `tgt_q`=0, `sh_cnt`=0, `jump_count`=0.

## Structure
- Package `jump_flush_pkg`:
  - `typedef enum logic [1:0] {IDLE, PEND, SHADOW} jf_state_t`.
  - Constants `JF_FLUSH_CYCLES_DEF`=2 and `JF_SH_CNT_W`=3.
- Single module with no sub-module; the shadow counter and perf counter are inline registers.
- One `always_ff` for state, `tgt_q`, `sh_cnt` and `jump_count`; one `always_comb` for next-state logic and outputs.

## Test plan
- Reset, then JAL with target 0x100 and `stall`=0 → same cycle: `pc_jump_control`=`local_rst`=`if_id_flush`=1, target 0x100; next cycle SHADOW (`local_rst`=1, `pc_jump_control`=0); IDLE after 2 total cycles; `jump_count`=1.
- Taken branch with target 0x2000 while `stall`=1 for 3 cycles → `enable_jump`=1 and `pc_jump_control`=0 for 3 cycles with target held at 0x2000 even as `exe_target` changes; fire in cycle 4; count +1.
- Not-taken branch (`exe_is_branch`=1, `exe_branch_taken`=0) → all outputs 0, count unchanged.
- Jump presented in EXE during SHADOW → ignored: no fire, no count change. Same jump presented the cycle after returning to IDLE → fires.
- `rst` asserted mid-PEND and mid-SHADOW → outputs 0 during reset, IDLE and `jump_count`=0 after the edge. FLUSH_CYCLES=1 → no SHADOW state entered.
- `jump_count` preloaded near wrap with CNT_W=4 by firing 16 jumps → reads 0 after the 16th fire.
